// File: rtl/pe_feeder_pkg.sv
// Shared definitions for the PE operand feeder: burst FSM states and the
// default operand/counter widths used on both sides of the PE interface.
package pe_feeder_pkg;

    localparam int PE_DATA_WIDTH = 16;
    localparam int PE_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } feeder_state_e;

endpackage

// File: rtl/pe_operand_feeder_fifo.sv
// Operand buffer: synchronous FIFO holding packed {residual, weight, input}
// triples. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate occupancy counter.
module operand_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Head of queue is presented combinationally so the consumer can
    // register it on the same edge that pops it.
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; flush empties the buffer without touching storage.
    always_ff @(posedge clk) begin
        if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pe_operand_feeder.sv
// Transmit side of the PE operand interface. Accepts operand triples from an
// upstream valid/ready stream, buffers them, and issues one triple per cycle
// to the PE for a programmed burst length, with a registered sparsity hint
// and saturating issue/sparse counters for cross-checking against the PE.
//
// state  | meaning
// IDLE   | waiting for start; counters hold last burst's results
// STREAM | accepting and issuing triples until burst_len have been issued
// DONE   | one-cycle end-of-burst pulse
module pe_operand_feeder
    import pe_feeder_pkg::*;
#(
    parameter int                    DATA_WIDTH         = PE_DATA_WIDTH,
    parameter int                    FIFO_DEPTH         = 8,
    parameter logic [DATA_WIDTH-1:0] SPARSITY_THRESHOLD = 16'h0010,
    parameter int                    CNT_WIDTH          = PE_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    input  logic                  mode_residual_in,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_input,
    input  logic [DATA_WIDTH-1:0] s_weight,
    input  logic [DATA_WIDTH-1:0] s_residual,
    output logic                  pe_en,
    output logic                  pe_mode_residual,
    output logic [DATA_WIDTH-1:0] pe_input_data,
    output logic [DATA_WIDTH-1:0] pe_weight_data,
    output logic [DATA_WIDTH-1:0] pe_residual_data,
    output logic                  pe_sparse_hint,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  issued_count,
    output logic [CNT_WIDTH-1:0]  sparse_count
);

    localparam int                   FIFO_WIDTH   = 3 * DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0]  SPARSE_LIMIT = {1'b0, SPARSITY_THRESHOLD};

    feeder_state_e         state_q, state_d;

    logic [CNT_WIDTH-1:0]  burst_len_q;
    logic [CNT_WIDTH-1:0]  accepted_q;
    logic [CNT_WIDTH-1:0]  issued_q;
    logic [CNT_WIDTH-1:0]  sparse_q;
    logic                  mode_q;
    logic                  pe_en_q;
    logic                  hint_q;
    logic [DATA_WIDTH-1:0] input_q;
    logic [DATA_WIDTH-1:0] weight_q;
    logic [DATA_WIDTH-1:0] residual_q;

    logic                  ready_c;
    logic                  busy_c;
    logic                  done_c;
    logic                  load_burst;
    logic                  burst_last;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_wdata;
    logic [FIFO_WIDTH-1:0] fifo_rdata;

    logic [DATA_WIDTH-1:0] head_input;
    logic [DATA_WIDTH-1:0] head_weight;
    logic [DATA_WIDTH-1:0] head_residual;
    logic                  head_sparse;

    // Magnitude one bit wider than the operand so the most negative value
    // maps to +2^(W-1) instead of wrapping back to itself.
    function automatic logic [DATA_WIDTH:0] magnitude(input logic [DATA_WIDTH-1:0] value);
        logic [DATA_WIDTH:0] wide;
        wide = {value[DATA_WIDTH-1], value};
        return value[DATA_WIDTH-1] ? -wide : wide;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] value);
        return (&value) ? value : value + CNT_ONE;
    endfunction

    assign fifo_wdata = {s_residual, s_weight, s_input};
    assign fifo_push  = s_valid && ready_c;

    operand_fifo #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .flush_i (rst),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_input    = fifo_rdata[DATA_WIDTH-1:0];
    assign head_weight   = fifo_rdata[2*DATA_WIDTH-1:DATA_WIDTH];
    assign head_residual = fifo_rdata[3*DATA_WIDTH-1:2*DATA_WIDTH];
    assign head_sparse   = (magnitude(head_input)  < SPARSE_LIMIT) ||
                           (magnitude(head_weight) < SPARSE_LIMIT);

    // Issue counter already includes the triple on the PE pins, so equality
    // during pe_en marks the final issue of the burst.
    assign burst_last = pe_en_q && (issued_q == burst_len_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (burst_len != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (burst_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded controls; ready is a function of registered state only.
    always_comb begin
        ready_c    = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        load_burst = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                load_burst = start;
            end
            STREAM: begin
                busy_c   = 1'b1;
                ready_c  = !fifo_full && (accepted_q < burst_len_q);
                fifo_pop = !fifo_empty;
            end
            DONE: begin
                done_c = 1'b1;
            end
            default: begin
                done_c = 1'b0;
            end
        endcase
    end

    // Burst configuration, acceptance/issue counters and PE output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_len_q <= '0;
            mode_q      <= 1'b0;
            accepted_q  <= '0;
            issued_q    <= '0;
            sparse_q    <= '0;
            pe_en_q     <= 1'b0;
            hint_q      <= 1'b0;
            input_q     <= '0;
            weight_q    <= '0;
            residual_q  <= '0;
        end else begin
            if (load_burst) begin
                burst_len_q <= burst_len;
                mode_q      <= mode_residual_in;
                accepted_q  <= '0;
                issued_q    <= '0;
                sparse_q    <= '0;
            end else begin
                if (fifo_push) begin
                    accepted_q <= accepted_q + CNT_ONE;
                end
                if (fifo_pop) begin
                    issued_q <= sat_inc(issued_q);
                    if (head_sparse) begin
                        sparse_q <= sat_inc(sparse_q);
                    end
                end
            end
            pe_en_q <= fifo_pop;
            if (fifo_pop) begin
                input_q    <= head_input;
                weight_q   <= head_weight;
                residual_q <= head_residual;
                hint_q     <= head_sparse;
            end
        end
    end

    assign s_ready          = ready_c;
    assign busy             = busy_c;
    assign done             = done_c;
    assign pe_en            = pe_en_q;
    assign pe_mode_residual = mode_q;
    assign pe_input_data    = input_q;
    assign pe_weight_data   = weight_q;
    assign pe_residual_data = residual_q;
    assign pe_sparse_hint   = hint_q;
    assign issued_count     = issued_q;
    assign sparse_count     = sparse_q;

endmodule
